// File: rtl/acc_pkg.sv
// Shared definitions for the multi-channel accumulator.
//   state_e           : controller states (IDLE, RUN, DRAIN)
//   DEF_*             : default width / configuration constants
//   clog2()           : ceiling log2 used to size the channel index
package acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_IN_DATA_WIDTH = 32'd8;
  localparam int DEF_DWIDTH        = 32'd16;
  localparam int DEF_NUM_CH        = 32'd4;
  localparam int DEF_SIGNED        = 32'd0;
  localparam int DEF_SAT           = 32'd1;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 32'd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 32'd1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Per-channel datapath: extends a sample to the accumulator width, adds it to
// the running sum, and either saturates or wraps on overflow.
//   acc_i    : current channel sum (DWIDTH)
//   sample_i : incoming sample (IN_DATA_WIDTH)
//   sum_o    : next channel sum (DWIDTH), clamped when SAT != 0
//   ovf_o    : this addition overflowed the representable range
module acc_sat_add #(
  parameter int IN_DATA_WIDTH = 32'd8,
  parameter int DWIDTH        = 32'd16,
  parameter int SIGNED        = 32'd0,
  parameter int SAT           = 32'd1
) (
  input  logic [DWIDTH-1:0]        acc_i,
  input  logic [IN_DATA_WIDTH-1:0] sample_i,
  output logic [DWIDTH-1:0]        sum_o,
  output logic                     ovf_o
);

  localparam logic [DWIDTH-1:0] SMAX = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0] SMIN = {1'b1, {(DWIDTH-1){1'b0}}};

  logic [DWIDTH-1:0] ext_s;
  logic [DWIDTH:0]   raw_s;
  logic [DWIDTH-1:0] clamp_s;
  logic              ovf_s;

  // A size cast of a signed operand sign-extends; of an unsigned one, zero-extends.
  if (SIGNED != 0) begin : g_sext
    assign ext_s = DWIDTH'($signed(sample_i));
  end else begin : g_zext
    assign ext_s = DWIDTH'(sample_i);
  end

  // Add, detect overflow in the active number system, pick clamp or wrapped value.
  always_comb begin
    raw_s   = {1'b0, acc_i} + {1'b0, ext_s};
    ovf_s   = 1'b0;
    clamp_s = {DWIDTH{1'b1}};
    if (SIGNED != 0) begin
      // Signed overflow: operands agree in sign but the sum does not.
      ovf_s   = (acc_i[DWIDTH-1] == ext_s[DWIDTH-1]) &&
                (raw_s[DWIDTH-1] != acc_i[DWIDTH-1]);
      clamp_s = acc_i[DWIDTH-1] ? SMIN : SMAX;
    end else begin
      ovf_s   = raw_s[DWIDTH];
      clamp_s = {DWIDTH{1'b1}};
    end
    if (ovf_s && (SAT != 0)) begin
      sum_o = clamp_s;
    end else begin
      sum_o = raw_s[DWIDTH-1:0];
    end
    ovf_o = ovf_s;
  end

endmodule

// File: rtl/acc_core_mc.sv
// Multi-channel accumulator. Samples are summed per channel while run_i is
// high; when run_i falls, each channel's sum is streamed out as one beat with a
// valid/ready handshake, after which all sums and overflow flags clear.
//   clk, rst            : clock, synchronous active-high reset
//   run_i               : accumulation window; its fall starts the drain
//   valid_i, ch_i,
//   number_i, ready_o   : sample input and its acceptance indicator
//   valid_o, out_ready_i: result beat handshake
//   ch_o, result_o,
//   ovf_o               : channel, sum and sticky overflow of the current beat
module acc_core_mc
  import acc_pkg::*;
#(
  parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
  parameter int DWIDTH        = DEF_DWIDTH,
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int SIGNED        = DEF_SIGNED,
  parameter int SAT           = DEF_SAT,
  localparam int CH_W         = (clog2(NUM_CH) > 32'd1) ? clog2(NUM_CH) : 32'd1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run_i,
  input  logic                     valid_i,
  input  logic [CH_W-1:0]          ch_i,
  input  logic [IN_DATA_WIDTH-1:0] number_i,
  output logic                     ready_o,
  input  logic                     out_ready_i,
  output logic                     valid_o,
  output logic [CH_W-1:0]          ch_o,
  output logic [DWIDTH-1:0]        result_o,
  output logic                     ovf_o
);

  // One extra bit so the channel count itself is representable.
  localparam logic [CH_W:0]   NUM_CH_L = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   d_q, d_d;
  logic [DWIDTH-1:0] acc_q [NUM_CH];
  logic [DWIDTH-1:0] acc_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DWIDTH-1:0] result_q, result_d;
  logic              ovf_out_q, ovf_out_d;

  logic [DWIDTH-1:0] sum_s [NUM_CH];
  logic [NUM_CH-1:0] add_ovf_s;
  logic              accept_s;
  logic              beat_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    acc_sat_add #(
      .IN_DATA_WIDTH(IN_DATA_WIDTH),
      .DWIDTH       (DWIDTH),
      .SIGNED       (SIGNED),
      .SAT          (SAT)
    ) u_add (
      .acc_i   (acc_q[g]),
      .sample_i(number_i),
      .sum_o   (sum_s[g]),
      .ovf_o   (add_ovf_s[g])
    );
  end

  // Next-state, accumulator update and next output-beat computation.
  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    ready_d   = 1'b1;
    ch_d      = {CH_W{1'b0}};
    result_d  = {DWIDTH{1'b0}};
    ovf_out_d = 1'b0;

    accept_s = valid_i && run_i && ready_q && (state_q != ST_DRAIN) &&
               ({1'b0, ch_i} < NUM_CH_L);
    beat_s   = (state_q == ST_DRAIN) && valid_q && out_ready_i;

    case (state_q)
      ST_IDLE: begin
        if (run_i) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!run_i) state_d = ST_DRAIN;
        else        state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (beat_s && (d_q == LAST_CH)) begin
          // Last beat taken: window closes and every channel starts fresh.
          state_d = ST_IDLE;
          d_d     = {CH_W{1'b0}};
          ovf_d   = {NUM_CH{1'b0}};
          for (int i = 0; i < NUM_CH; i++) acc_d[i] = {DWIDTH{1'b0}};
        end else if (beat_s) begin
          d_d = d_q + CH_W'(1);
        end else begin
          d_d = d_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < NUM_CH; i++) begin
      if (accept_s && (ch_i == CH_W'(i))) begin
        acc_d[i] = sum_s[i];
        ovf_d[i] = ovf_q[i] | add_ovf_s[i];
      end else begin
        acc_d[i] = acc_d[i];
      end
    end

    // Outputs are registered from the next state, so the first beat appears
    // one cycle after run_i is seen low and holds while the sink stalls.
    if (state_d == ST_DRAIN) begin
      valid_d = 1'b1;
      ready_d = 1'b0;
      ch_d    = d_d;
      for (int i = 0; i < NUM_CH; i++) begin
        result_d  = (d_d == CH_W'(i)) ? acc_q[i] : result_d;
        ovf_out_d = (d_d == CH_W'(i)) ? ovf_q[i] : ovf_out_d;
      end
    end else begin
      valid_d = 1'b0;
      ready_d = 1'b1;
    end
  end

  // State, accumulator and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      d_q       <= {CH_W{1'b0}};
      ovf_q     <= {NUM_CH{1'b0}};
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      ch_q      <= {CH_W{1'b0}};
      result_q  <= {DWIDTH{1'b0}};
      ovf_out_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= {DWIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      ch_q      <= ch_d;
      result_q  <= result_d;
      ovf_out_q <= ovf_out_d;
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign ch_o     = ch_q;
  assign result_o = result_q;
  assign ovf_o    = ovf_out_q;

endmodule

// File: doc/acc_core_mc.md
ACC_CORE_MC -- requirements
Module: acc_core_mc

Interface
REQ-001 SHALL have parameter IN_DATA_WIDTH, default 8, sample width.
REQ-002 SHALL have parameter DWIDTH, default 16, accumulator/result width (DWIDTH >= IN_DATA_WIDTH).
REQ-003 SHALL have parameter NUM_CH, default 4, channel count (1..16).
REQ-004 SHALL have parameter SIGNED, default 0, 1 = two's-complement samples and results.
REQ-005 SHALL have parameter SAT, default 1, 1 = saturate on overflow, 0 = wrap modulo 2^DWIDTH.
REQ-006 SHALL have the port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have the port rst, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have the port run_i, input, 1, accumulation window; its fall starts drain.
REQ-009 SHALL have the port valid_i, input, 1, sample qualifier.
REQ-010 SHALL have the port ch_i, input, CH_W = max(1, clog2(NUM_CH)), target channel.
REQ-011 SHALL have the port number_i, input, IN_DATA_WIDTH, sample.
REQ-012 SHALL have the port ready_o, output, 1, high in IDLE and RUN; samples accepted only when high.
REQ-013 SHALL have the port out_ready_i, input, 1, downstream accepts the result beat.
REQ-014 SHALL have the port valid_o, output, 1, result beat valid.
REQ-015 SHALL have the port ch_o, output, CH_W, channel of the current beat.
REQ-016 SHALL have the port result_o, output, DWIDTH, channel sum.
REQ-017 SHALL have the port ovf_o, output, 1, sticky overflow flag of the current channel.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-019 IDLE->RUN when run_i=1; RUN->DRAIN when run_i=0; DRAIN->IDLE after the beat for channel NUM_CH-1 is accepted.
REQ-020 Sample accepted when valid_i && run_i && ready_o && ch_i < NUM_CH, in IDLE or RUN; acc[ch_i] updates at that edge, so IDLE-cycle samples are not lost.
REQ-021 A sample with ch_i >= NUM_CH SHALL be dropped with no state change.
REQ-022 Samples SHALL be zero-extended (SIGNED=0) or sign-extended (SIGNED=1) to DWIDTH before addition.
REQ-023 SAT=1: overflowing sum clamps to max (unsigned 2^DWIDTH-1; signed 2^(DWIDTH-1)-1) or min (signed -2^(DWIDTH-1)); SAT=0: sum wraps.
REQ-024 Each channel SHALL keep a sticky ovf bit, set on any overflow in either mode, cleared only by reset or drain completion.
REQ-025 In DRAIN: valid_o=1, ch_o=drain counter d (starts 0), result_o=acc[d], ovf_o=ovf[d]; all registered, no combinational input-to-output path.
REQ-026 First beat SHALL appear the cycle after the edge where run_i is sampled 0 (one-cycle latency).
REQ-027 Beat accepted when valid_o && out_ready_i: d increments; outputs SHALL hold stable while out_ready_i=0.
REQ-028 On acceptance of the last beat, all acc and ovf SHALL clear to 0 and FSM enters IDLE at the same edge.
REQ-029 In DRAIN, ready_o=0 and valid_i/run_i SHALL be ignored; run_i=1 at drain end starts a new window only from IDLE on the following cycle.
REQ-030 Outside DRAIN, valid_o=0 and ch_o, result_o, ovf_o SHALL be 0.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, d=0, all acc=0, all ovf=0, valid_o=0, ch_o=0, result_o=0, ovf_o=0, ready_o=1 the next cycle, in any state including mid-DRAIN.
REQ-032 rst SHALL take priority over every sample, handshake and state transition in the same cycle.

Structure
REQ-033 A shared package acc_pkg SHALL hold the FSM state encodings, default width constants and the clog2 function.
REQ-034 One sub-module acc_sat_add SHALL implement the per-channel extend/add/saturate/overflow datapath, instantiated NUM_CH times.

Verification
REQ-035 Defaults, ch 0, samples 1..100 one per cycle, drop run_i -> beats ch 0..3 = 5050, 0, 0, 0; ovf_o=0.
REQ-036 Samples 1..8 round-robin over ch 0..3 -> results 6, 8, 10, 12.
REQ-037 SAT=1, ch 0, 300 samples of 255 -> result 65535, ovf_o=1; SAT=0 -> 10964, ovf_o=1.
REQ-038 SIGNED=1, SAT=1, ch 1, 300 samples of 0x80 (-128) -> result -32768 (0x8000), ovf_o=1.
REQ-039 out_ready_i low for 3 cycles on beat ch 2 -> ch_o=2 and result held; ready_o=0 throughout DRAIN; valid_i pulses ignored.
REQ-040 rst pulse during beat ch 1 -> next cycle all outputs 0, IDLE; new window of 5 samples of 3 on ch 0 -> result 15.
